// File: rtl/pipelined_mult_acc.sv
// Pipelined A_W x B_W multiplier with optional running accumulation.
// Valid/ready on both sides; the whole pipe stalls as one when output is held.
module pipelined_mult_acc #(
  parameter int A_W    = 9,
  parameter int B_W    = 9,
  parameter int ACC_W  = 36,
  parameter int PIPE   = 2,
  parameter int SIGNED = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a_in,
  input  logic [B_W-1:0]     b_in,
  input  logic               acc_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] prod_out,
  output logic [ACC_W-1:0]   acc_out,
  output logic               ovf
);

  localparam int P_W = A_W + B_W;

  // Operands are extended to full product width first; the
  // truncated product is then exact for both signednesses.
  function automatic logic [P_W-1:0] mul(
    input logic [A_W-1:0] a,
    input logic [B_W-1:0] b
  );
    logic [P_W-1:0] ax;
    logic [P_W-1:0] bx;
    if (SIGNED != 0) begin
      ax = P_W'($signed(a));
      bx = P_W'($signed(b));
    end else begin
      ax = P_W'(a);
      bx = P_W'(b);
    end
    return ax * bx;
  endfunction

  logic           advance;
  logic           src_v;
  logic [P_W-1:0] src_p;
  logic           src_en;

  logic             out_valid_q, out_valid_d;
  logic [P_W-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  generate
    if (PIPE == 1) begin : g_comb
      always_comb begin
        src_v  = in_valid;
        src_p  = mul(a_in, b_in);
        src_en = acc_en;
      end
    end else begin : g_pipe
      logic           s1_v_q, s1_v_d;
      logic           s1_en_q, s1_en_d;
      logic [A_W-1:0] s1_a_q, s1_a_d;
      logic [B_W-1:0] s1_b_q, s1_b_d;
      logic [P_W-1:0] s1_p;

      always_comb begin
        s1_v_d  = s1_v_q;
        s1_en_d = s1_en_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        if (advance) begin
          s1_v_d  = in_valid;
          s1_en_d = acc_en;
          s1_a_d  = a_in;
          s1_b_d  = b_in;
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s1_v_q  <= 1'b0;
          s1_en_q <= 1'b0;
          s1_a_q  <= '0;
          s1_b_q  <= '0;
        end else begin
          s1_v_q  <= s1_v_d;
          s1_en_q <= s1_en_d;
          s1_a_q  <= s1_a_d;
          s1_b_q  <= s1_b_d;
        end
      end

      assign s1_p = mul(s1_a_q, s1_b_q);

      if (PIPE == 2) begin : g_d2
        always_comb begin
          src_v  = s1_v_q;
          src_p  = s1_p;
          src_en = s1_en_q;
        end
      end else begin : g_deep
        localparam int N = PIPE - 2;

        logic [N-1:0]          pv_q, pv_d;
        logic [N-1:0]          pen_q, pen_d;
        logic [N-1:0][P_W-1:0] pp_q, pp_d;

        always_comb begin
          pv_d  = pv_q;
          pen_d = pen_q;
          pp_d  = pp_q;
          if (advance) begin
            pv_d[0]  = s1_v_q;
            pen_d[0] = s1_en_q;
            pp_d[0]  = s1_p;
            for (int i = 1; i < N; i++) begin
              pv_d[i]  = pv_q[i-1];
              pen_d[i] = pen_q[i-1];
              pp_d[i]  = pp_q[i-1];
            end
          end
        end

        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            pv_q  <= '0;
            pen_q <= '0;
            pp_q  <= '0;
          end else begin
            pv_q  <= pv_d;
            pen_q <= pen_d;
            pp_q  <= pp_d;
          end
        end

        always_comb begin
          src_v  = pv_q[N-1];
          src_p  = pp_q[N-1];
          src_en = pen_q[N-1];
        end
      end
    end
  endgenerate

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             sovf;
  logic             add_ovf;

  always_comb begin
    if (SIGNED != 0) ext = ACC_W'($signed(src_p));
    else             ext = ACC_W'(src_p);
    {carry, sum} = {1'b0, acc_q} + {1'b0, ext};
    sovf    = (acc_q[ACC_W-1] == ext[ACC_W-1])
           && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    add_ovf = (SIGNED != 0) ? sovf : carry;
  end

  // The accumulator only moves when a real beat lands in the output stage.
  always_comb begin
    out_valid_d = out_valid_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (advance) begin
      out_valid_d = src_v;
      if (src_v) begin
        prod_d = src_p;
        if (src_en) begin
          acc_d = sum;
          if (add_ovf) ovf_d = 1'b1;
        end else begin
          acc_d = ext;
          ovf_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign prod_out  = prod_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_mult_acc.sv
// Directed scoreboard bench: an unsigned 18-bit-acc instance
// and a signed 36-bit-acc instance share clock, reset and out_ready.
module tb_pipelined_mult_acc;

  typedef struct {
    logic [17:0] p;
    logic [35:0] a;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic out_ready = 1'b1;

  logic        v_u = 1'b0, en_u = 1'b0;
  logic [8:0]  a_u = '0, b_u = '0;
  logic        rdy_u, ov_u, ovf_u;
  logic [17:0] prod_u;
  logic [17:0] acc_u;

  logic        v_s = 1'b0, en_s = 1'b0;
  logic [8:0]  a_s = '0, b_s = '0;
  logic        rdy_s, ov_s, ovf_s;
  logic [17:0] prod_s;
  logic [35:0] acc_s;

  exp_t q_u[$];
  exp_t q_s[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pipelined_mult_acc #(
    .A_W(9), .B_W(9), .ACC_W(18), .PIPE(2), .SIGNED(0)
  ) dut_u (
    .clock(clk), .reset(rst),
    .in_valid(v_u), .in_ready(rdy_u),
    .a_in(a_u), .b_in(b_u), .acc_en(en_u),
    .out_valid(ov_u), .out_ready(out_ready),
    .prod_out(prod_u), .acc_out(acc_u), .ovf(ovf_u)
  );

  pipelined_mult_acc #(
    .A_W(9), .B_W(9), .ACC_W(36), .PIPE(2), .SIGNED(1)
  ) dut_s (
    .clock(clk), .reset(rst),
    .in_valid(v_s), .in_ready(rdy_s),
    .a_in(a_s), .b_in(b_s), .acc_en(en_s),
    .out_valid(ov_s), .out_ready(out_ready),
    .prod_out(prod_s), .acc_out(acc_s), .ovf(ovf_s)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, got, want);
  endtask

  // Monitor: pops expected results whenever a DUT hands one over.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && out_ready && ov_u) begin
      if (q_u.size() == 0) chk("u_unexpected_out", 1, 0);
      else begin
        e = q_u.pop_front();
        chk("u_prod", 64'(prod_u), 64'(e.p));
        chk("u_acc", 64'(acc_u), 64'(e.a));
        chk("u_ovf", 64'(ovf_u), 64'(e.o));
      end
    end
    if (!rst && out_ready && ov_s) begin
      if (q_s.size() == 0) chk("s_unexpected_out", 1, 0);
      else begin
        e = q_s.pop_front();
        chk("s_prod", 64'(prod_s), 64'(e.p));
        chk("s_acc", 64'(acc_s), 64'(e.a));
        chk("s_ovf", 64'(ovf_s), 64'(e.o));
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input bit sel, input logic [8:0] a,
                      input logic [8:0] b, input logic en,
                      input bit push, input logic [17:0] ep,
                      input logic [35:0] ea, input logic eo);
    int n = 0;
    exp_t e;
    if (sel) begin a_s = a; b_s = b; en_s = en; v_s = 1'b1; end
    else     begin a_u = a; b_u = b; en_u = en; v_u = 1'b1; end
    #1;
    while (!(sel ? rdy_s : rdy_u) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    e.p = ep; e.a = ea; e.o = eo;
    if (push) begin
      if (sel) q_s.push_back(e);
      else     q_u.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    v_u = 1'b0;
    v_s = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_u", 64'(q_u.size()), 0);
    chk("drain_s", 64'(q_s.size()), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(ov_u), 0);
    chk("rst_prod", 64'(prod_u), 0);
    chk("rst_acc", 64'(acc_u), 0);
    chk("rst_ovf", 64'(ovf_u), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(rdy_u), 1);
    @(negedge clk);

    // Latency: 3*5 appears one cycle after acceptance
    send(0, 9'd3, 9'd5, 1'b0, 1, 18'd15, 36'd15, 1'b0);
    idle();
    #1 chk("lat_early", 64'(ov_u), 0);
    @(negedge clk);
    #1 chk("lat_on_time", 64'(ov_u), 1);
    @(negedge clk);
    drain();

    // Signed products
    send(1, 9'h1FF, 9'h1FF, 1'b0, 1, 18'd1, 36'd1, 1'b0);
    send(1, 9'h100, 9'h001, 1'b0, 1, 18'h3FF00,
         36'hFFFFFFF00, 1'b0);
    send(1, 9'h100, 9'h1FF, 1'b1, 1, 18'h00100, 36'd0, 1'b0);
    idle();
    drain();

    // Back-to-back accumulation
    send(0, 9'd2, 9'd2, 1'b0, 1, 18'd4, 36'd4, 1'b0);
    send(0, 9'd2, 9'd2, 1'b1, 1, 18'd4, 36'd8, 1'b0);
    send(0, 9'd2, 9'd2, 1'b1, 1, 18'd4, 36'd12, 1'b0);
    send(0, 9'd2, 9'd2, 1'b1, 1, 18'd4, 36'd16, 1'b0);
    send(0, 9'd1, 9'd1, 1'b0, 1, 18'd1, 36'd1, 1'b0);
    idle();
    drain();

    // Backpressure: hold output 3 cycles with beat 0 presented
    send(0, 9'd1, 9'd1, 1'b0, 1, 18'd1, 36'd1, 1'b0);
    send(0, 9'd2, 9'd3, 1'b1, 1, 18'd6, 36'd7, 1'b0);
    out_ready = 1'b0;
    a_u = 9'd4; b_u = 9'd5; en_u = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_out_valid", 64'(ov_u), 1);
      chk("bp_in_ready", 64'(rdy_u), 0);
      chk("bp_prod_stable", 64'(prod_u), 1);
      chk("bp_acc_stable", 64'(acc_u), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(0, 9'd4, 9'd5, 1'b1, 1, 18'd20, 36'd27, 1'b0);
    send(0, 9'd10, 9'd10, 1'b1, 1, 18'd100, 36'd127, 1'b0);
    idle();
    drain();

    // Overflow: wrap at 2^18, sticky, then cleared
    send(0, 9'd511, 9'd511, 1'b0, 1, 18'd261121, 36'd261121, 1'b0);
    send(0, 9'd511, 9'd511, 1'b1, 1, 18'd261121, 36'd260098, 1'b1);
    send(0, 9'd1, 9'd1, 1'b1, 1, 18'd1, 36'd260099, 1'b1);
    send(0, 9'd2, 9'd3, 1'b0, 1, 18'd6, 36'd6, 1'b0);
    idle();
    drain();

    // Reset mid-flight with ovf set and two beats in the pipe
    send(0, 9'd511, 9'd511, 1'b0, 1, 18'd261121, 36'd261121, 1'b0);
    send(0, 9'd511, 9'd511, 1'b1, 1, 18'd261121, 36'd260098, 1'b1);
    idle();
    drain();
    send(0, 9'd5, 9'd5, 1'b1, 0, 18'd0, 36'd0, 1'b0);
    send(0, 9'd6, 9'd6, 1'b1, 0, 18'd0, 36'd0, 1'b0);
    chk("pre_rst_ovf", 64'(ovf_u), 1);
    rst = 1'b1;
    idle();
    #1;
    chk("mid_rst_valid", 64'(ov_u), 0);
    chk("mid_rst_acc", 64'(acc_u), 0);
    chk("mid_rst_ovf", 64'(ovf_u), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("post_rst_no_out", 64'(ov_u), 0);
    end
    @(negedge clk);
    send(0, 9'd3, 9'd4, 1'b1, 1, 18'd12, 36'd12, 1'b0);
    idle();
    drain();

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
